// File: rtl/fe_readout_sequencer_if.sv
// Trigger/configuration and readout bundle for the FE readout sequencer.
// The master side is the trigger logic and DAQ register bank. The slave side is the sequencer.
interface fe_readout_sequencer_if #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 7
);
  // Control and run-time configuration (master -> sequencer)
  logic                 en;
  logic                 trig;
  logic [DIV_WIDTH-1:0] fe_clk_div;
  logic [DIV_WIDTH-1:0] fe_clk_duty;
  logic [31:0]          int_trig_period;

  // FE chain / ADC sequencing outputs (sequencer -> master)
  logic                 fe_hold;
  logic                 fe_clk;
  logic                 fe_shift;
  logic                 adc_start;
  logic [CNT_WIDTH-1:0] ch_cnt;
  logic                 busy;
  logic                 done;
  logic                 trig_lost;

  modport master (
    output en, trig, fe_clk_div, fe_clk_duty, int_trig_period,
    input  fe_hold, fe_clk, fe_shift, adc_start, ch_cnt, busy, done, trig_lost
  );

  modport slave (
    input  en, trig, fe_clk_div, fe_clk_duty, int_trig_period,
    output fe_hold, fe_clk, fe_shift, adc_start, ch_cnt, busy, done, trig_lost
  );
endinterface

// File: rtl/fe_readout_sequencer.sv
// FE readout sequencer: on trigger, holds the FE chain and clocks out FE_CLOCK_CYCLES channels.
// It issues one ADC-start strobe on each FE clock falling edge.
// Optional macro INT_TRIG_EN adds a periodic internal trigger. The internal trigger is ORed with the external one.
module fe_readout_sequencer #(
  parameter int FE_CLOCK_CYCLES = 64,
  parameter int DIV_WIDTH       = 16,
  parameter int HOLD_DELAY      = 4,
  parameter int CNT_WIDTH       = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fe_readout_sequencer_if.slave bus
);

  localparam int HOLD_W = (HOLD_DELAY > 1) ? $clog2(HOLD_DELAY) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, CLOCK, DONE} state_t;

  state_t               state_reg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] duty_reg;
  logic [DIV_WIDTH-1:0] phase_reg;
  logic [CNT_WIDTH-1:0] ch_reg;
  logic [HOLD_W-1:0]    hold_cnt_reg;
  logic                 hold_reg;
  logic                 fe_clk_reg;
  logic                 shift_reg;
  logic                 adc_start_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 trig_lost_reg;

  logic [DIV_WIDTH-1:0] div_clamp;
  logic [DIV_WIDTH-1:0] duty_clamp;
  logic                 phase_wrap;
  logic                 last_ch;
  logic [DIV_WIDTH-1:0] phase_next;
  logic [CNT_WIDTH-1:0] ch_next;
  logic                 trig_any;

`ifdef INT_TRIG_EN
  logic [31:0] int_cnt_reg;
  logic        int_trig;

  // The internal trigger fires when the free-running count reaches period-1. A period of 0 disables it.
  assign int_trig = bus.en && (bus.int_trig_period != 32'd0)
                    && (int_cnt_reg >= bus.int_trig_period - 32'd1);

  // The free-running counter is held at 0 while the sequencer is disabled.
  // It restarts after every internal trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt_reg <= 32'd0;
    end else if (!bus.en || int_trig) begin
      int_cnt_reg <= 32'd0;
    end else begin
      int_cnt_reg <= int_cnt_reg + 32'd1;
    end
  end

  assign trig_any = bus.trig | int_trig;
`else
  // The period input has no consumer without the internal trigger.
  logic unused_period;
  assign unused_period = ^bus.int_trig_period;
  assign trig_any      = bus.trig;
`endif

  // Clamp the live configuration so the latched period is at least 2.
  // The high time is clamped so that both FE clock phases are non-empty.
  always_comb begin
    div_clamp = (bus.fe_clk_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : bus.fe_clk_div;
    if (bus.fe_clk_duty == '0) begin
      duty_clamp = DIV_WIDTH'(1);
    end else if (bus.fe_clk_duty >= div_clamp) begin
      duty_clamp = div_clamp - DIV_WIDTH'(1);
    end else begin
      duty_clamp = bus.fe_clk_duty;
    end
  end

  // Phase and channel advance during CLOCK. Outputs are registered from these next values.
  always_comb begin
    phase_wrap = (phase_reg == div_reg - DIV_WIDTH'(1));
    last_ch    = (ch_reg == CNT_WIDTH'(FE_CLOCK_CYCLES - 1));
    phase_next = phase_wrap ? '0 : phase_reg + DIV_WIDTH'(1);
    ch_next    = phase_wrap ? ch_reg + CNT_WIDTH'(1) : ch_reg;
  end

  // Readout FSM. The outputs are registered with the value belonging to the cycle being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      div_reg       <= DIV_WIDTH'(2);
      duty_reg      <= DIV_WIDTH'(1);
      phase_reg     <= '0;
      ch_reg        <= '0;
      hold_cnt_reg  <= '0;
      hold_reg      <= 1'b0;
      fe_clk_reg    <= 1'b0;
      shift_reg     <= 1'b0;
      adc_start_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      trig_lost_reg <= 1'b0;
    end else begin
      adc_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      // Any trigger while busy, including one in the DONE cycle, is dropped and flagged.
      if (trig_any && busy_reg) begin
        trig_lost_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (trig_any && bus.en) begin
            div_reg       <= div_clamp;
            duty_reg      <= duty_clamp;
            ch_reg        <= '0;
            hold_cnt_reg  <= '0;
            trig_lost_reg <= 1'b0;
            busy_reg      <= 1'b1;
            hold_reg      <= 1'b1;
            state_reg     <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_reg == HOLD_W'(HOLD_DELAY - 1)) begin
            // The first period starts high because the duty is always at least 1.
            state_reg  <= CLOCK;
            phase_reg  <= '0;
            fe_clk_reg <= 1'b1;
            shift_reg  <= 1'b1;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        CLOCK: begin
          if (phase_wrap && last_ch) begin
            state_reg  <= DONE;
            done_reg   <= 1'b1;
            fe_clk_reg <= 1'b0;
            shift_reg  <= 1'b0;
          end else begin
            phase_reg     <= phase_next;
            ch_reg        <= ch_next;
            fe_clk_reg    <= (phase_next < duty_reg);
            shift_reg     <= (ch_next == '0);
            adc_start_reg <= (phase_next == duty_reg);
          end
        end
        DONE: begin
          state_reg  <= IDLE;
          busy_reg   <= 1'b0;
          hold_reg   <= 1'b0;
          fe_clk_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.fe_hold   = hold_reg;
  assign bus.fe_clk    = fe_clk_reg;
  assign bus.fe_shift  = shift_reg;
  assign bus.adc_start = adc_start_reg;
  assign bus.ch_cnt    = ch_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.trig_lost = trig_lost_reg;

endmodule

// File: tb/tb_fe_readout_sequencer.sv
// Scoreboard bench for fe_readout_sequencer with FE_CLOCK_CYCLES=4 and HOLD_DELAY=4.
module tb_fe_readout_sequencer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int HD = 4;
  localparam int CW = 7;

  localparam int ACT_NONE   = 0;
  localparam int ACT_TRIG   = 1;
  localparam int ACT_EN_OFF = 2;
  localparam int ACT_CFG    = 3;
  localparam int ACT_RST    = 4;

  typedef struct {
    int cyc;
    int ch;
  } adc_ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   sb_on    = 1'b1;

  adc_ev_t adc_q[$];
  int      done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fe_readout_sequencer_if #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fe_readout_sequencer #(
    .FE_CLOCK_CYCLES(N),
    .DIV_WIDTH(DW),
    .HOLD_DELAY(HD),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int outs_vec();
    return int'({bus.busy, bus.fe_hold, bus.fe_clk, bus.fe_shift, bus.adc_start,
                 bus.done, bus.trig_lost, bus.ch_cnt});
  endfunction

  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int eff_duty(input int h, input int d);
    if (h == 0) return 1;
    if (h >= d) return d - 1;
    return h;
  endfunction

  // Output side of the scoreboard: every strobe must match the next expected event.
  always @(negedge clk) begin
    adc_ev_t e;
    int      dc;
    if (sb_on && rst_n) begin
      if (bus.adc_start) begin
        if (adc_q.size() == 0) check_val("adc_unexpected", cyc, -1);
        else begin
          e = adc_q.pop_front();
          check_val("adc_cycle", cyc, e.cyc);
          check_val("adc_ch", int'(bus.ch_cnt), e.ch);
          $display("adc_start cyc=%0d ch=%0d", cyc, bus.ch_cnt);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) check_val("done_unexpected", cyc, -1);
        else begin
          dc = done_q.pop_front();
          check_val("done_cycle", cyc, dc);
          $display("done cyc=%0d", cyc);
        end
      end
    end
  end

  // Run one readout. Expected ADC and DONE events are pushed at trigger time.
  // One disturbance is optionally applied at relative cycle 'at'.
  task automatic readout(input int div, input int duty, input int act, input int at);
    adc_ev_t ev;
    int d, h, t, total, busy_cnt, wave_err, ck;
    bit in_clk, e_clk, e_shift, e_busy, aborted;
    d = eff_div(div);
    h = eff_duty(duty, d);
    total = HD + N * d + 1;
    busy_cnt = 0;
    wave_err = 0;
    aborted = 1'b0;
    @(negedge clk);
    bus.fe_clk_div  = DW'(div);
    bus.fe_clk_duty = DW'(duty);
    bus.en   = 1'b1;
    bus.trig = 1'b1;
    t = cyc;
    for (int i = 0; i < N; i++) begin
      ev.cyc = t + HD + 1 + h + i * d;
      ev.ch  = i;
      adc_q.push_back(ev);
    end
    done_q.push_back(t + total);
    $display("trigger cyc=%0d div=%0d duty=%0d act=%0d", t, div, duty, act);
    @(negedge clk);
    for (int k = 1; k <= total + 2; k++) begin
      bus.trig = (act == ACT_TRIG && k == at);
      if (act == ACT_EN_OFF && k == at) bus.en = 1'b0;
      if (act == ACT_CFG && k == at) begin
        bus.fe_clk_div  = DW'(1);
        bus.fe_clk_duty = DW'(7);
      end
      if (k == 1) check_val("lost_cleared", int'(bus.trig_lost), 0);
      if (act == ACT_RST && k == at) begin
        check_val("ch_before_rst", int'(bus.ch_cnt), 2);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outs", outs_vec(), 0);
        adc_q.delete();
        done_q.delete();
        aborted = 1'b1;
        break;
      end
      ck      = k - HD - 1;
      in_clk  = (ck >= 0) && (ck < N * d);
      e_clk   = in_clk && ((ck % d) < h);
      e_shift = in_clk && (ck < d);
      e_busy  = (k <= total);
      if (bus.busy != e_busy || bus.fe_hold != e_busy || bus.fe_clk != e_clk
          || bus.fe_shift != e_shift) begin
        wave_err++;
      end
      busy_cnt += int'(bus.busy);
      @(negedge clk);
    end
    bus.trig = 1'b0;
    if (aborted) begin
      repeat (3) @(negedge clk);
      check_val("rst_hold_outs", outs_vec(), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_val("no_done_after_rst", int'(bus.busy), 0);
    end else begin
      check_val("busy_len", busy_cnt, total);
      check_val("wave_err", wave_err, 0);
      check_val("adc_left", adc_q.size(), 0);
      check_val("done_left", done_q.size(), 0);
      check_val("trig_lost", int'(bus.trig_lost), (act == ACT_TRIG) ? 1 : 0);
    end
  endtask

  initial begin
    int done_cnt;
    bit lost_seen;
    bus.en = 1'b0;
    bus.trig = 1'b0;
    bus.fe_clk_div = DW'(4);
    bus.fe_clk_duty = DW'(2);
    bus.int_trig_period = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("reset_outs", outs_vec(), 0);
    rst_n = 1'b1;

    // Trigger without enable is ignored
    @(negedge clk);
    bus.trig = 1'b1;
    @(negedge clk);
    bus.trig = 1'b0;
    check_val("no_en_busy", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    check_val("no_en_busy_late", int'(bus.busy), 0);

    readout(4, 2, ACT_NONE, 0);             // basic timing
    readout(0, 0, ACT_NONE, 0);             // clamp to period 2, high 1
    readout(5, 9, ACT_NONE, 0);             // high time clamped to 4
    readout(3, 1, ACT_NONE, 0);
    readout(4, 2, ACT_TRIG, 8);             // trigger lost mid-CLOCK
    readout(3, 1, ACT_NONE, 0);             // accepted trigger clears the flag
    readout(4, 2, ACT_TRIG, HD + N * 4 + 1);// trigger in the DONE cycle
    readout(4, 2, ACT_EN_OFF, 6);           // disable mid-readout completes
    readout(4, 3, ACT_CFG, 3);              // config change while busy ignored
    readout(4, 2, ACT_RST, HD + 1 + 2 * 4); // reset at channel 2
    readout(4, 2, ACT_NONE, 0);             // full readout after reset

`ifdef INT_TRIG_EN
    sb_on = 1'b0;
    bus.en = 1'b0;
    bus.fe_clk_div = DW'(2);
    bus.fe_clk_duty = DW'(1);
    bus.int_trig_period = 32'd100;
    @(negedge clk);
    bus.en = 1'b1;
    done_cnt = 0;
    lost_seen = 1'b0;
    for (int k = 0; k < 350; k++) begin
      @(negedge clk);
      done_cnt += int'(bus.done);
      lost_seen |= bus.trig_lost;
    end
    check_val("int_trig_dones", done_cnt, 3);
    check_val("int_trig_no_lost", int'(lost_seen), 0);
    bus.int_trig_period = 32'd10;
    repeat (100) @(negedge clk);
    check_val("int_trig_lost", int'(bus.trig_lost), 1);
    bus.int_trig_period = 32'd0;
    bus.en = 1'b0;
    repeat (30) @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fe_readout_sequencer.md
Name: fe_readout_sequencer

Overview:
Sequences one readout cycle of the microstrip front-end (FE) chain and its ADCs.
- On a trigger it asserts the FE hold and generates FE_CLOCK_CYCLES periods of the FE clock, with a programmable period and high time.
- It injects the shift-in token in the first period and issues one ADC-start strobe per FE channel.
- It sits between the trigger logic and the ADC deserialisers and is configured at run time from the DAQ register bank.

Parameters:
FE_CLOCK_CYCLES, 64, FE channels clocked per readout (one ADC conversion each)
DIV_WIDTH, 16, width of the divider and duty configuration inputs
HOLD_DELAY, 4, iCLK cycles between hold assertion and the first FE clock edge
CNT_WIDTH, 7, width of the channel counter (must hold FE_CLOCK_CYCLES)

Ports:
iCLK  in  1  system fast clock
iRSTn  in  1  asynchronous active-low reset
iEN  in  1  sequencer enable; 0 = triggers ignored
iTRIG  in  1  external trigger, single-cycle pulse, synchronous to iCLK
iFE_CLK_DIV  in  DIV_WIDTH  FE clock period in iCLK cycles
iFE_CLK_DUTY  in  DIV_WIDTH  FE clock high time in iCLK cycles
iINT_TRIG_PERIOD  in  32  internal trigger period (used only with the macro)
oFE_HOLD  out  1  FE sample-and-hold
oFE_CLK  out  1  FE shift clock
oFE_SHIFT  out  1  FE shift-in token
oADC_START  out  1  one-cycle strobe starting one ADC conversion
oCH_CNT  out  CNT_WIDTH  index of the channel being converted
oBUSY  out  1  readout in progress
oDONE  out  1  one-cycle end-of-readout pulse
oTRIG_LOST  out  1  sticky flag: trigger arrived while busy

Behaviour:
- Clock and reset: one clock, iCLK. Reset is asynchronous, active-low, on iRSTn. All outputs are registered. While iRSTn is low, every output is 0 and the FSM is in IDLE.
- Reset mid-operation: readout is aborted immediately. No oDONE pulse; the FE clock simply stops.
- FSM states: IDLE -> HOLD -> CLOCK -> DONE -> IDLE.
- IDLE:
  - iTRIG=1 with iEN=1 latches the config into internal registers, then enters HOLD on the next cycle.
  - From that cycle on: oBUSY=1, oFE_HOLD=1.
- Config clamping (applied at latch):
  - div = max(iFE_CLK_DIV, 2).
  - duty = clamped into 1..div-1: 0 becomes 1; duty >= div becomes div-1.
  - Config changes while busy have no effect until the next trigger.
- HOLD: stays exactly HOLD_DELAY cycles, then enters CLOCK.
- CLOCK:
  - Phase counter runs 0..div-1 and wraps; channel counter runs 0..FE_CLOCK_CYCLES-1.
  - oFE_CLK = 1 while phase < duty.
  - oFE_SHIFT = 1 for the whole first period (channel 0) only.
  - oADC_START pulses for one cycle when phase == duty (FE clock falling edge), with oCH_CNT = current channel.
  - On phase wrap of the last channel, enter DONE.
  - Duration: FE_CLOCK_CYCLES*div cycles.
- DONE (one cycle):
  - oDONE=1; oFE_HOLD, oFE_CLK and oBUSY go 0 on the following cycle.
  - Then IDLE, accepting a new trigger the cycle after DONE.
- Total oBUSY high time: HOLD_DELAY + FE_CLOCK_CYCLES*div + 1 cycles.
- oCH_CNT: holds its last value after readout; reset value 0; cleared on the next trigger.
- Busy trigger:
  - Any iTRIG while oBUSY=1 is ignored and sets oTRIG_LOST.
  - The flag clears only on reset or on a trigger accepted with iEN=1 from IDLE.
  - A trigger in the DONE cycle counts as lost.
- iEN deasserted mid-readout does not abort; the current readout completes.

Optional Feature:
Macro INT_TRIG_EN.
- Defined:
  - A 32-bit free-running counter, active while iEN=1, produces an internal trigger every iINT_TRIG_PERIOD iCLK cycles.
  - The internal trigger is ORed with iTRIG. Period 0 disables the internal trigger.
  - The counter resets to 0 on iRSTn and when iEN=0.
  - Internal triggers that hit a busy sequencer set oTRIG_LOST like external ones.
- Undefined: no counter logic; iINT_TRIG_PERIOD is unused; only iTRIG starts readout.

Test Plan:
1. Reset: iRSTn low -> all outputs 0. Release, iTRIG without iEN -> oBUSY stays 0.
2. Basic timing: FE_CLOCK_CYCLES=4, HOLD_DELAY=4, div=4, duty=2, trigger at cycle T ->
   - oFE_HOLD high from T+1.
   - oFE_CLK high at T+5..6, T+9..10, T+13..14, T+17..18.
   - oADC_START at T+7, 11, 15, 19 with oCH_CNT 0..3.
   - oFE_SHIFT high T+5..8; oDONE at T+21; oBUSY high 21 cycles.
3. Clamping: div=0, duty=0 -> period 2, high 1. div=5, duty=9 -> high 4, oADC_START at phase 4.
4. Busy trigger: second iTRIG mid-CLOCK -> no restart, oTRIG_LOST=1. Next accepted trigger after oDONE -> oTRIG_LOST=0.
5. Reset mid-CLOCK: iRSTn low at channel 2 -> outputs 0 immediately, no oDONE. A trigger after release gives a full readout from channel 0.
6. INT_TRIG_EN: period=100, iEN=1, div=2, FE_CLOCK_CYCLES=4 -> a readout starts every 100 cycles with oTRIG_LOST=0. Period=10 -> oTRIG_LOST set.
